// File: rtl/pkg_sorter_if.sv
// pkg_sorter_param_if: scale, threshold-programming and host readback signals of the package sorter
interface pkg_sorter_param_if #(
  parameter int W_WIDTH   = 12,
  parameter int NUM_GRP   = 6,
  parameter int CNT_WIDTH = 8,
  parameter int TOT_WIDTH = 16
);
  localparam int GI = $clog2(NUM_GRP + 1);
  logic [W_WIDTH-1:0]   Weight;
  logic                 thr_we;
  logic [GI-1:0]        thr_idx;
  logic [W_WIDTH-1:0]   thr_data;
  logic                 clr_all;
  logic [GI-1:0]        rd_idx;
  logic [CNT_WIDTH-1:0] rd_count;
  logic [GI-1:0]        CurrentGrp;
  logic                 item_valid;
  logic [GI-1:0]        item_grp;
  logic [TOT_WIDTH-1:0] total;
  logic [NUM_GRP-1:0]   sat;
  modport master (
    output Weight, thr_we, thr_idx, thr_data, clr_all, rd_idx,
    input  rd_count, CurrentGrp, item_valid, item_grp, total, sat
  );
  modport slave (
    input  Weight, thr_we, thr_idx, thr_data, clr_all, rd_idx,
    output rd_count, CurrentGrp, item_valid, item_grp, total, sat
  );
endinterface

// File: rtl/pkg_sorter_param.sv
// pkg_sorter_param: classifies settled package weights into threshold groups and keeps
// saturating per-group counts, a wrapping total and sticky saturation flags.
module pkg_sorter_param #(
  parameter int W_WIDTH    = 12,
  parameter int NUM_GRP    = 6,
  parameter int CNT_WIDTH  = 8,
  parameter int TOT_WIDTH  = 16,
  parameter int STABLE_CYC = 2,
  parameter logic [(NUM_GRP-1)*W_WIDTH-1:0] THR_INIT =
    {12'd2000, 12'd1000, 12'd800, 12'd500, 12'd200}
) (
  input logic CLK,
  input logic Reset,
  pkg_sorter_param_if.slave bus
);
  localparam int GI = $clog2(NUM_GRP + 1);
  localparam int SW = $clog2(STABLE_CYC + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, HOLD} state_t;
  state_t                            state_q, state_d;
  logic [SW-1:0]                     stab_q, stab_d;
  logic [W_WIDTH-1:0]                weight_q, ref_q, ref_d;
  logic [NUM_GRP-1:1][W_WIDTH-1:0]   thr_q, thr_d;
  logic [NUM_GRP:1][CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [TOT_WIDTH-1:0]              total_q, total_d;
  logic [NUM_GRP-1:0]                sat_q, sat_d;
  logic [CNT_WIDTH-1:0]              rd_q, rd_d;
  logic [GI-1:0]                     cur_grp_q, item_grp_q, grp_w, grp_ref;
  logic                              item_valid_q, counting;

  // First matching threshold wins, so non-monotonic tables still give a defined group
  function automatic logic [GI-1:0] classify(input logic [W_WIDTH-1:0] w,
                                             input logic [NUM_GRP-1:1][W_WIDTH-1:0] t);
    logic [GI-1:0] g_o;
    g_o = GI'(NUM_GRP);
    for (int g = NUM_GRP - 1; g >= 1; g--) if (w <= t[g]) g_o = GI'(g);
    return (w == '0) ? '0 : g_o;
  endfunction

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    ref_d   = ref_q;
    case (state_q)
      IDLE: if (weight_q != '0) begin
        ref_d   = weight_q;
        stab_d  = SW'(1);
        state_d = (STABLE_CYC == 1) ? COUNT : SETTLE;
      end
      SETTLE: if (weight_q == '0) state_d = IDLE;
        else if (weight_q != ref_q) begin
          ref_d  = weight_q;
          stab_d = SW'(1);
        end
        else if (int'(stab_q) + 1 >= STABLE_CYC) state_d = COUNT;
        else stab_d = stab_q + SW'(1);
      COUNT: state_d = HOLD;
      default: if (weight_q == '0) state_d = IDLE;
    endcase
  end

  // Clear is applied before the increment so a count landing with clr_all survives as 1
  always_comb begin
    counting = (state_q == COUNT);
    grp_w    = classify(weight_q, thr_q);
    grp_ref  = classify(ref_q, thr_q);
    cnt_d    = bus.clr_all ? '0 : cnt_q;
    sat_d    = bus.clr_all ? '0 : sat_q;
    total_d  = (bus.clr_all ? '0 : total_q) + TOT_WIDTH'(counting);
    thr_d    = thr_q;
    rd_d     = '0;
    for (int g = 1; g <= NUM_GRP; g++) begin
      if (counting && grp_ref == GI'(g)) begin
        if (&cnt_d[g]) sat_d[g-1] = 1'b1;
        else cnt_d[g] = cnt_d[g] + 1'b1;
      end
      if (bus.rd_idx == GI'(g)) rd_d = cnt_q[g];
    end
    for (int g = 1; g < NUM_GRP; g++)
      if (bus.thr_we && bus.thr_idx == GI'(g)) thr_d[g] = bus.thr_data;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      stab_q       <= '0;
      weight_q     <= '0;
      ref_q        <= '0;
      thr_q        <= THR_INIT;
      cnt_q        <= '0;
      total_q      <= '0;
      sat_q        <= '0;
      rd_q         <= '0;
      cur_grp_q    <= '0;
      item_valid_q <= 1'b0;
      item_grp_q   <= '0;
    end else begin
      state_q      <= state_d;
      stab_q       <= stab_d;
      weight_q     <= bus.Weight;
      ref_q        <= ref_d;
      thr_q        <= thr_d;
      cnt_q        <= cnt_d;
      total_q      <= total_d;
      sat_q        <= sat_d;
      rd_q         <= rd_d;
      cur_grp_q    <= grp_w;
      item_valid_q <= counting;
      item_grp_q   <= counting ? grp_ref : '0;
    end
  end

  assign bus.rd_count   = rd_q;
  assign bus.CurrentGrp = cur_grp_q;
  assign bus.item_valid = item_valid_q;
  assign bus.item_grp   = item_grp_q;
  assign bus.total      = total_q;
  assign bus.sat        = sat_q;
endmodule

// File: tb/tb_pkg_sorter_param.sv
// tb_pkg_sorter_param: directed scenarios plus a randomized weight stream checked
// against a run-length item model and a plain threshold lookup.
module tb_pkg_sorter_param;
  localparam int W_WIDTH = 12, NUM_GRP = 6, CNT_WIDTH = 8, TOT_WIDTH = 16, STABLE_CYC = 2;
  localparam int GI = $clog2(NUM_GRP + 1);
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0, n_err = 0, n_items = 0, last_grp = 0;
  int thr_m [1:NUM_GRP-1];

  pkg_sorter_param_if #(.W_WIDTH(W_WIDTH), .NUM_GRP(NUM_GRP), .CNT_WIDTH(CNT_WIDTH),
                        .TOT_WIDTH(TOT_WIDTH)) bus ();
  pkg_sorter_param #(.W_WIDTH(W_WIDTH), .NUM_GRP(NUM_GRP), .CNT_WIDTH(CNT_WIDTH),
                     .TOT_WIDTH(TOT_WIDTH), .STABLE_CYC(STABLE_CYC)) dut (
    .CLK(clk), .Reset(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(negedge clk) if (bus.item_valid) begin n_items++; last_grp = int'(bus.item_grp); end

  function automatic void init_thr();
    thr_m[1] = 200; thr_m[2] = 500; thr_m[3] = 800; thr_m[4] = 1000; thr_m[5] = 2000;
  endfunction

  function automatic int ref_grp(input int w);
    if (w == 0) return 0;
    for (int g = 1; g < NUM_GRP; g++) if (w <= thr_m[g]) return g;
    return NUM_GRP;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic item(input int w, input int hold);
    for (int i = 0; i < hold; i++) begin @(negedge clk); bus.Weight = W_WIDTH'(w); end
    for (int i = 0; i < 4; i++) begin @(negedge clk); bus.Weight = '0; end
  endtask

  task automatic rd(input int g, output int v);
    @(negedge clk); bus.rd_idx = GI'(g);
    @(negedge clk); v = int'(bus.rd_count);
  endtask

  task automatic clr();
    @(negedge clk); bus.clr_all = 1'b1;
    @(negedge clk); bus.clr_all = 1'b0;
  endtask

  task automatic wr_thr(input int idx, input int d);
    @(negedge clk); bus.thr_we = 1'b1; bus.thr_idx = GI'(idx); bus.thr_data = W_WIDTH'(d);
    @(negedge clk); bus.thr_we = 1'b0;
    if (idx >= 1 && idx < NUM_GRP) thr_m[idx] = d;
  endtask

  task automatic test_reset();
    tick(2);
    n_cmp++; if (bus.item_valid !== 1'b0 || bus.item_grp !== '0) begin n_err++; $display("FAIL reset_item: valid %0b grp %0d, want 0 0", bus.item_valid, bus.item_grp); end
    n_cmp++; if (bus.total !== '0 || bus.sat !== '0) begin n_err++; $display("FAIL reset_tot_sat: total %0d sat %b, want 0 0", bus.total, bus.sat); end
    n_cmp++; if (bus.CurrentGrp !== '0 || bus.rd_count !== '0) begin n_err++; $display("FAIL reset_grp_rd: grp %0d rd %0d, want 0 0", bus.CurrentGrp, bus.rd_count); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_defaults();
    int n0, v;
    n0 = n_items;
    item(150, 4);
    n_cmp++; if (n_items - n0 !== 1) begin n_err++; $display("FAIL default_items: got %0d want 1", n_items - n0); end
    n_cmp++; if (last_grp !== 1) begin n_err++; $display("FAIL default_grp: got %0d want 1", last_grp); end
    rd(1, v);
    n_cmp++; if (v !== 1) begin n_err++; $display("FAIL default_cnt1: got %0d want 1", v); end
    n_cmp++; if (int'(bus.total) !== 1) begin n_err++; $display("FAIL default_total: got %0d want 1", bus.total); end
  endtask

  task automatic test_boundaries();
    int ws [8] = '{200, 201, 500, 800, 1000, 2000, 2001, 4095};
    int gs [8] = '{1, 2, 2, 3, 4, 5, 6, 6};
    int n0, t0;
    t0 = int'(bus.total);
    for (int i = 0; i < 8; i++) begin
      n0 = n_items;
      @(negedge clk); bus.Weight = W_WIDTH'(ws[i]);
      tick(3);
      n_cmp++; if (int'(bus.CurrentGrp) !== gs[i]) begin n_err++; $display("FAIL bound_curgrp w=%0d: got %0d want %0d", ws[i], bus.CurrentGrp, gs[i]); end
      @(negedge clk); bus.Weight = '0;
      tick(4);
      n_cmp++; if (n_items - n0 !== 1 || last_grp !== gs[i]) begin n_err++; $display("FAIL bound_item w=%0d: items %0d grp %0d, want 1 %0d", ws[i], n_items - n0, last_grp, gs[i]); end
    end
    n_cmp++; if (int'(bus.total) !== t0 + 8) begin n_err++; $display("FAIL bound_total: got %0d want %0d", bus.total, t0 + 8); end
  endtask

  task automatic test_glitch();
    int n0, t0;
    n0 = n_items; t0 = int'(bus.total);
    item(300, 1);
    n_cmp++; if (n_items !== n0 || int'(bus.total) !== t0) begin n_err++; $display("FAIL glitch: items %0d total %0d, want %0d %0d", n_items, bus.total, n0, t0); end
    @(negedge clk); bus.Weight = 12'd100;
    @(negedge clk); bus.Weight = 12'd300;
    item(600, 4);
    n_cmp++; if (n_items - n0 !== 1 || last_grp !== 3) begin n_err++; $display("FAIL ramp: items %0d grp %0d, want 1 3", n_items - n0, last_grp); end
    n_cmp++; if (int'(bus.total) !== t0 + 1) begin n_err++; $display("FAIL ramp_total: got %0d want %0d", bus.total, t0 + 1); end
  endtask

  task automatic test_saturation();
    int v;
    clr();
    repeat (260) item(900, 2);
    rd(4, v);
    n_cmp++; if (v !== 255) begin n_err++; $display("FAIL sat_cnt4: got %0d want 255", v); end
    n_cmp++; if (bus.sat !== 6'b001000) begin n_err++; $display("FAIL sat_flags: got %b want 001000", bus.sat); end
    n_cmp++; if (int'(bus.total) !== 260) begin n_err++; $display("FAIL sat_total: got %0d want 260", bus.total); end
    rd(0, v);
    n_cmp++; if (v !== 0) begin n_err++; $display("FAIL rd_idx0: got %0d want 0", v); end
    rd(7, v);
    n_cmp++; if (v !== 0) begin n_err++; $display("FAIL rd_idx7: got %0d want 0", v); end
    clr();
    n_cmp++; if (bus.sat !== '0 || bus.total !== '0) begin n_err++; $display("FAIL clr_sat_total: sat %b total %0d, want 0 0", bus.sat, bus.total); end
    for (int g = 1; g <= NUM_GRP; g++) begin
      rd(g, v);
      n_cmp++; if (v !== 0) begin n_err++; $display("FAIL clr_cnt%0d: got %0d want 0", g, v); end
    end
  endtask

  task automatic test_reprogram();
    int n0, v;
    wr_thr(1, 50);
    wr_thr(0, 10);
    wr_thr(7, 10);
    item(100, 3);
    n_cmp++; if (last_grp !== 2) begin n_err++; $display("FAIL reprog_100: got %0d want 2", last_grp); end
    item(40, 3);
    item(40, 3);
    n_cmp++; if (last_grp !== 1) begin n_err++; $display("FAIL reprog_40: got %0d want 1", last_grp); end
    rd(2, v);
    n_cmp++; if (v !== 1) begin n_err++; $display("FAIL reprog_cnt2: got %0d want 1", v); end
    n0 = n_items;
    @(negedge clk); bus.Weight = 12'd30;
    tick(2);
    @(negedge clk); bus.clr_all = 1'b1;
    @(negedge clk); bus.clr_all = 1'b0; bus.Weight = '0;
    tick(3);
    n_cmp++; if (n_items - n0 !== 1 || last_grp !== 1) begin n_err++; $display("FAIL clr_count_item: items %0d grp %0d, want 1 1", n_items - n0, last_grp); end
    rd(1, v);
    n_cmp++; if (v !== 1) begin n_err++; $display("FAIL clr_count_cnt1: got %0d want 1", v); end
    rd(2, v);
    n_cmp++; if (v !== 0) begin n_err++; $display("FAIL clr_count_cnt2: got %0d want 0", v); end
    n_cmp++; if (int'(bus.total) !== 1) begin n_err++; $display("FAIL clr_count_total: got %0d want 1", bus.total); end
  endtask

  task automatic test_reset_mid();
    int n0, v;
    n0 = n_items;
    @(negedge clk); bus.Weight = 12'd700;
    tick(2);
    rst = 1'b1; bus.Weight = '0;
    @(negedge clk);
    init_thr();
    n_cmp++; if (bus.total !== '0 || bus.item_valid !== 1'b0 || bus.CurrentGrp !== '0) begin n_err++; $display("FAIL rst_settle: total %0d valid %0b grp %0d, want 0", bus.total, bus.item_valid, bus.CurrentGrp); end
    rst = 1'b0;
    tick(4);
    n_cmp++; if (n_items !== n0) begin n_err++; $display("FAIL rst_settle_nocount: got %0d want %0d", n_items, n0); end
    item(100, 3);
    n_cmp++; if (last_grp !== 1) begin n_err++; $display("FAIL rst_thr_init: got %0d want 1", last_grp); end
    for (int i = 0; i < 6; i++) begin @(negedge clk); bus.Weight = 12'd900; end
    rst = 1'b1; bus.Weight = '0;
    @(negedge clk);
    rst = 1'b0;
    rd(4, v);
    n_cmp++; if (v !== 0 || bus.total !== '0 || bus.sat !== '0) begin n_err++; $display("FAIL rst_hold: cnt4 %0d total %0d sat %b, want 0", v, bus.total, bus.sat); end
    n0 = n_items;
    item(150, 4);
    n_cmp++; if (n_items - n0 !== 1 || last_grp !== 1 || int'(bus.total) !== 1) begin n_err++; $display("FAIL rst_next_item: items %0d grp %0d total %0d, want 1 1 1", n_items - n0, last_grp, bus.total); end
  endtask

  task automatic test_random();
    int s[$];
    bit exp_v[];
    int exp_g[];
    int cm [1:NUM_GRP];
    int tot, len, rv, rl, w, g, v;
    bit counted;
    for (int i = 1; i < NUM_GRP; i++) wr_thr(i, int'($urandom_range(1, 4095)));
    clr();
    tick(2);
    s = {0, 0, 0};
    repeat (40) begin
      repeat ($urandom_range(1, 3)) begin
        w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(1, 4095));
        repeat ($urandom_range(1, 3)) s.push_back(w);
      end
      repeat ($urandom_range(2, 4)) s.push_back(0);
    end
    len = s.size();
    exp_v = new[len + 8];
    exp_g = new[len + 8];
    for (int i = 1; i <= NUM_GRP; i++) cm[i] = 0;
    tot = 0; rv = 0; rl = 0; counted = 1'b0;
    // An item is accepted on the STABLE_CYC-th identical nonzero sample since the belt emptied
    for (int k = 0; k < len; k++) begin
      w = s[k];
      if (w == 0) begin counted = 1'b0; rl = 0; end
      else if (!counted) begin
        if (rl > 0 && w == rv) rl++;
        else begin rv = w; rl = 1; end
        if (rl == STABLE_CYC) begin
          counted = 1'b1;
          g = ref_grp(w);
          exp_v[k + 3] = 1'b1;
          exp_g[k + 3] = g;
          if (cm[g] < 255) cm[g]++;
          tot++;
        end
      end
    end
    for (int k = 0; k < len + 8; k++) begin
      @(negedge clk);
      if (k >= 2 && k - 2 < len) begin
        n_cmp++; if (int'(bus.CurrentGrp) !== ref_grp(s[k-2])) begin n_err++; $display("FAIL rand_curgrp k=%0d w=%0d: got %0d want %0d", k, s[k-2], bus.CurrentGrp, ref_grp(s[k-2])); end
      end
      n_cmp++; if (bus.item_valid !== exp_v[k]) begin n_err++; $display("FAIL rand_valid k=%0d: got %0b want %0b", k, bus.item_valid, exp_v[k]); end
      if (exp_v[k]) begin
        n_cmp++; if (int'(bus.item_grp) !== exp_g[k]) begin n_err++; $display("FAIL rand_grp k=%0d: got %0d want %0d", k, bus.item_grp, exp_g[k]); end
      end
      bus.Weight = (k < len) ? W_WIDTH'(s[k]) : '0;
    end
    for (int i = 1; i <= NUM_GRP; i++) begin
      rd(i, v);
      n_cmp++; if (v !== cm[i]) begin n_err++; $display("FAIL rand_cnt%0d: got %0d want %0d", i, v, cm[i]); end
    end
    n_cmp++; if (int'(bus.total) !== tot) begin n_err++; $display("FAIL rand_total: got %0d want %0d", bus.total, tot); end
  endtask

  initial begin
    bus.Weight = '0; bus.thr_we = 1'b0; bus.thr_idx = '0; bus.thr_data = '0;
    bus.clr_all = 1'b0; bus.rd_idx = '0;
    init_thr();
    test_reset();
    test_defaults();
    test_boundaries();
    test_glitch();
    test_saturation();
    test_reprogram();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
